contador_param: RTL and testbench

Parametrised successor to the 32-bit four-mode counter: a `WIDTH`-bit synchronous counter with a run-time modulus (`LIMIT`), a parametrised step for the multi-step down mode, and a saturating wrap-event counter.

- Modes: up, down, down-by-`STEP`, parallel load.
- Outputs are registered.
- `RCO` and `LOAD` are single-cycle event flags.
- It is the general counting primitive for timers and dividers in the design.

---
 rtl/contador_param_pkg.sv | 12 +
 rtl/contador_param_if.sv | 19 +
 rtl/contador_param.sv | 74 +++++++
 tb/tb_contador_param.sv | 116 +++++++++++
 4 files changed

// File: rtl/contador_param_pkg.sv
// contador_pkg: shared mode encodings and MODO width for contador_param.
//   COUNT_UP        - increment, wrap to 0 past LIMIT
//   COUNT_DOWN      - decrement, wrap to LIMIT below 0
//   COUNT_STEP_DOWN - decrement by STEP, wrap modulo LIMIT+1
//   CHARGE          - parallel load of D
package contador_pkg;
    localparam int MODO_W = 2;
    localparam logic [MODO_W-1:0] COUNT_UP        = 2'b00;
    localparam logic [MODO_W-1:0] COUNT_DOWN      = 2'b01;
    localparam logic [MODO_W-1:0] COUNT_STEP_DOWN = 2'b10;
    localparam logic [MODO_W-1:0] CHARGE          = 2'b11;
endpackage

// File: rtl/contador_param_if.sv
// contador_param_if: control and status bundle of contador_param.
//   master drives ENABLE, MODO, D, LIMIT and observes Q, RCO, LOAD, WRAPS;
//   slave (the counter) is the mirror image.
interface contador_param_if #(
    parameter int WIDTH  = 32,
    parameter int WRAP_W = 8
);
    import contador_pkg::*;
    logic              ENABLE;
    logic [MODO_W-1:0] MODO;
    logic [WIDTH-1:0]  D;
    logic [WIDTH-1:0]  LIMIT;
    logic [WIDTH-1:0]  Q;
    logic              RCO;
    logic              LOAD;
    logic [WRAP_W-1:0] WRAPS;
    modport master (output ENABLE, MODO, D, LIMIT, input Q, RCO, LOAD, WRAPS);
    modport slave  (input ENABLE, MODO, D, LIMIT, output Q, RCO, LOAD, WRAPS);
endinterface

// File: rtl/contador_param.sv
// contador_param: WIDTH-bit modulus counter (up / down / down-by-STEP / load)
// with single-cycle RCO and LOAD flags and a saturating wrap counter.
//   clk   - rising-edge clock
//   RESET - synchronous active-high reset
//   bus   - slave side of contador_param_if (ENABLE, MODO, D, LIMIT in;
//           Q, RCO, LOAD, WRAPS out, all registered)
module contador_param
    import contador_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP   = 3,
    parameter int WRAP_W = 8
) (
    input logic             clk,
    input logic             RESET,
    contador_param_if.slave bus
);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
    logic [WIDTH-1:0]  r_q;
    logic              r_rco;
    logic              r_load;
    logic [WRAP_W-1:0] r_wraps;
    logic [WIDTH-1:0]  w_q_next;
    logic              w_wrap;
    logic              w_load;
    logic [WIDTH:0]    w_sum;
    // Q+LIMIT+1 kept one bit wider so LIMIT = all-ones wraps exactly.
    assign w_sum = {1'b0, r_q} + {1'b0, bus.LIMIT} + (WIDTH+1)'(1);
    always_comb begin
        w_q_next = r_q;
        w_wrap   = 1'b0;
        w_load   = 1'b0;
        if (bus.ENABLE) begin
            case (bus.MODO)
                COUNT_UP: begin
                    w_wrap   = r_q >= bus.LIMIT;
                    w_q_next = w_wrap ? '0 : r_q + WIDTH'(1);
                end
                COUNT_DOWN: begin
                    w_wrap   = r_q == '0;
                    w_q_next = w_wrap ? bus.LIMIT : r_q - WIDTH'(1);
                end
                COUNT_STEP_DOWN: begin
                    w_wrap   = {1'b0, r_q} < STEP_X;
                    // A wrap that would still land below zero parks at LIMIT.
                    w_q_next = !w_wrap ? r_q - STEP_N :
                               (w_sum < STEP_X) ? bus.LIMIT : WIDTH'(w_sum - STEP_X);
                end
                CHARGE: begin
                    w_load   = 1'b1;
                    w_q_next = bus.D;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_q     <= '0;
            r_rco   <= 1'b0;
            r_load  <= 1'b0;
            r_wraps <= '0;
        end else begin
            r_q     <= w_q_next;
            r_rco   <= w_wrap;
            r_load  <= w_load;
            r_wraps <= w_load ? '0 : (w_wrap && !(&r_wraps)) ? r_wraps + WRAP_W'(1) : r_wraps;
        end
    end
    assign bus.Q     = r_q;
    assign bus.RCO   = r_rco;
    assign bus.LOAD  = r_load;
    assign bus.WRAPS = r_wraps;
endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: directed table-driven bench for contador_param
// (WIDTH=8, STEP=3, WRAP_W=2) plus a modulus-period sequence.
module tb_contador_param;
    import contador_pkg::*;
    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] m;
        logic [7:0] d;
        logic [7:0] lim;
        logic [7:0] q;
        logic       rco;
        logic       ld;
        logic [1:0] wr;
    } vec_t;
    logic clk = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tv[$];
    contador_param_if #(.WIDTH(8), .WRAP_W(2)) bus ();
    contador_param #(.WIDTH(8), .STEP(3), .WRAP_W(2)) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic [7:0] d, logic [7:0] l,
                                logic [7:0] q, logic c, logic ld, logic [1:0] w);
        vec_t v;
        v.rst = r; v.en = e; v.m = m; v.d = d; v.lim = l;
        v.q = q; v.rco = c; v.ld = ld; v.wr = w;
        return v;
    endfunction
    task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask
    task automatic drive(logic r, logic e, logic [1:0] m, logic [7:0] d, logic [7:0] l);
        @(negedge clk);
        RESET = r; bus.ENABLE = e; bus.MODO = m; bus.D = d; bus.LIMIT = l;
        @(posedge clk);
        #1;
    endtask
    initial begin
        int rco_cnt;
        logic [7:0] eq;
        RESET = 1'b1; bus.ENABLE = 1'b0; bus.MODO = CHARGE; bus.D = '0; bus.LIMIT = '0;
        // reset wins over load
        tv.push_back(mk(1, 1, CHARGE, 8'h55, 8'hFF, 8'h00, 0, 0, 0));
        tv.push_back(mk(1, 1, CHARGE, 8'h55, 8'hFF, 8'h00, 0, 0, 0));
        // load and full-range wrap
        tv.push_back(mk(0, 1, CHARGE, 8'hFD, 8'hFF, 8'hFD, 0, 1, 0));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'hFF, 8'hFE, 0, 0, 0));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'hFF, 8'hFF, 0, 0, 0));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'hFF, 8'h00, 1, 0, 1));
        // step-down wrap with LIMIT=9
        tv.push_back(mk(0, 1, CHARGE, 8'h01, 8'h09, 8'h01, 0, 1, 0));
        tv.push_back(mk(0, 1, COUNT_STEP_DOWN, 8'h00, 8'h09, 8'h08, 1, 0, 1));
        tv.push_back(mk(0, 1, COUNT_STEP_DOWN, 8'h00, 8'h09, 8'h05, 0, 0, 1));
        tv.push_back(mk(0, 1, COUNT_STEP_DOWN, 8'h00, 8'h09, 8'h02, 0, 0, 1));
        tv.push_back(mk(0, 1, COUNT_STEP_DOWN, 8'h00, 8'h09, 8'h09, 1, 0, 2));
        // hold
        tv.push_back(mk(0, 0, COUNT_UP, 8'h00, 8'h09, 8'h09, 0, 0, 2));
        tv.push_back(mk(0, 0, COUNT_DOWN, 8'h00, 8'h09, 8'h09, 0, 0, 2));
        tv.push_back(mk(0, 0, CHARGE, 8'h33, 8'h09, 8'h09, 0, 0, 2));
        // down wrap from 0, and down above LIMIT without clamp
        tv.push_back(mk(0, 1, CHARGE, 8'h00, 8'h05, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 1, COUNT_DOWN, 8'h00, 8'h05, 8'h05, 1, 0, 1));
        tv.push_back(mk(0, 1, COUNT_DOWN, 8'h00, 8'h05, 8'h04, 0, 0, 1));
        tv.push_back(mk(0, 1, CHARGE, 8'h14, 8'h05, 8'h14, 0, 1, 0));
        tv.push_back(mk(0, 1, COUNT_DOWN, 8'h00, 8'h05, 8'h13, 0, 0, 0));
        // step-down with LIMIT=0: negative wrap parks at LIMIT every cycle
        tv.push_back(mk(0, 1, CHARGE, 8'h00, 8'h00, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 1, COUNT_STEP_DOWN, 8'h00, 8'h00, 8'h00, 1, 0, 1));
        tv.push_back(mk(0, 1, COUNT_STEP_DOWN, 8'h00, 8'h00, 8'h00, 1, 0, 2));
        // step-down wrap with LIMIT=FF must stay exact
        tv.push_back(mk(0, 1, CHARGE, 8'h01, 8'hFF, 8'h01, 0, 1, 0));
        tv.push_back(mk(0, 1, COUNT_STEP_DOWN, 8'h00, 8'hFF, 8'hFE, 1, 0, 1));
        // WRAPS saturation then load clears it
        tv.push_back(mk(0, 1, CHARGE, 8'h00, 8'h00, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'h00, 8'h00, 1, 0, 1));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'h00, 8'h00, 1, 0, 2));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'h00, 8'h00, 1, 0, 3));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'h00, 8'h00, 1, 0, 3));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'h00, 8'h00, 1, 0, 3));
        tv.push_back(mk(0, 1, CHARGE, 8'h07, 8'h00, 8'h07, 0, 1, 0));
        // reset mid-count, resume from 0
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'h09, 8'h08, 0, 0, 0));
        tv.push_back(mk(1, 1, COUNT_UP, 8'h00, 8'h09, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, COUNT_UP, 8'h00, 8'h09, 8'h01, 0, 0, 0));
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].en, tv[i].m, tv[i].d, tv[i].lim);
            chk("Q", i, bus.Q, tv[i].q);
            chk("RCO", i, {7'd0, bus.RCO}, {7'd0, tv[i].rco});
            chk("LOAD", i, {7'd0, bus.LOAD}, {7'd0, tv[i].ld});
            chk("WRAPS", i, {6'd0, bus.WRAPS}, {6'd0, tv[i].wr});
        end
        // modulus 10: period of 10, one RCO pulse per period
        drive(1, 0, COUNT_UP, 8'h00, 8'h09);
        rco_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, COUNT_UP, 8'h00, 8'h09);
            eq = 8'((i + 1) % 10);
            chk("mod_Q", i, bus.Q, eq);
            chk("mod_RCO", i, {7'd0, bus.RCO}, {7'd0, eq == 8'h00});
            if (bus.RCO) rco_cnt++;
        end
        chk("mod_RCO_count", 0, 8'(rco_cnt), 8'd2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
